// File: rtl/csr_pkg.sv
// Shared constants and helpers for the Zicntr/Zihpm counter bank.
package csr_pkg;

    // Low-half addresses; the high half of a counter sits at +CsrHiOffset.
    localparam logic [11:0] CsrCycle         = 12'hC00;
    localparam logic [11:0] CsrTime          = 12'hC01;
    localparam logic [11:0] CsrInstret       = 12'hC02;
    localparam logic [11:0] CsrHpmcounter3   = 12'hC03;
    localparam logic [11:0] CsrMcycle        = 12'hB00;
    localparam logic [11:0] CsrMinstret      = 12'hB02;
    localparam logic [11:0] CsrMhpmcounter3  = 12'hB03;
    localparam logic [11:0] CsrMcountinhibit = 12'h320;
    localparam logic [11:0] CsrMhpmevent3    = 12'h323;
    localparam logic [11:0] CsrHiOffset      = 12'h080;

    localparam logic [2:0] F3Rw  = 3'b001;
    localparam logic [2:0] F3Rs  = 3'b010;
    localparam logic [2:0] F3Rc  = 3'b011;
    localparam logic [2:0] F3Rwi = 3'b101;
    localparam logic [2:0] F3Rsi = 3'b110;
    localparam logic [2:0] F3Rci = 3'b111;

    // Counter slot index doubles as the mcountinhibit bit index.
    localparam int unsigned IdxCycle   = 0;
    localparam int unsigned IdxTime    = 1;
    localparam int unsigned IdxInstret = 2;
    localparam int unsigned IdxHpm3    = 3;

    typedef enum logic [1:0] {OpNone, OpRw, OpRs, OpRc} csr_op_e;

    function automatic csr_op_e csr_decode_op(logic [2:0] f3);
        case (f3)
            F3Rw, F3Rwi: return OpRw;
            F3Rs, F3Rsi: return OpRs;
            F3Rc, F3Rci: return OpRc;
            default:     return OpNone;
        endcase
    endfunction

    function automatic logic [31:0] csr_merge(csr_op_e op, logic [31:0] old_val,
                                              logic [31:0] val);
        case (op)
            OpRw:    return val;
            OpRs:    return old_val | val;
            OpRc:    return old_val & ~val;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter.sv
// One CNT_WIDTH counter with per-half write strobes; a write wins over the increment.
module csr_counter #(
    parameter int unsigned CNT_WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    input  logic                 wr_lo_i,
    input  logic                 wr_hi_i,
    input  logic [31:0]          wdata_i,
    output logic [CNT_WIDTH-1:0] value_o
);

    logic [CNT_WIDTH-1:0] value_q, value_d;
    logic [63:0]          merged;

    always_comb begin
        // Merge in a 64-bit view so bits at or above CNT_WIDTH drop out naturally.
        merged = 64'(value_q);
        if (wr_lo_i) merged[31:0] = wdata_i;
        if (wr_hi_i) merged[63:32] = wdata_i;
        if (wr_lo_i || wr_hi_i) begin
            value_d = merged[CNT_WIDTH-1:0];
        end else if (inc_i) begin
            value_d = value_q + CNT_WIDTH'(1);
        end else begin
            value_d = value_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;

endmodule

// File: rtl/csr_counter_bank.sv
// Zicntr/Zihpm counter bank: decode, RW/RS/RC merge, inhibit, event select and time prescaler.
module csr_counter_bank
    import csr_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 64,
    parameter int unsigned NUM_HPM    = 4,
    parameter int unsigned NUM_EVENTS = 8,
    parameter int unsigned TIME_DIV   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_retired,
    input  logic [NUM_EVENTS-1:0] hpm_events,
    input  logic [11:0]           csr_num,
    input  logic                  read_csr,
    input  logic                  write_csr,
    input  logic [2:0]            write_function,
    input  logic [31:0]           write_value,
    output logic [31:0]           read_value,
    output logic                  illegal_instr_exception
);

    localparam int unsigned NumCnt  = IdxHpm3 + NUM_HPM;
    localparam int unsigned HpmA    = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int unsigned EvW     = $clog2(NUM_EVENTS + 1);
    localparam int unsigned PreW    = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
    localparam logic [31:0] InhMask = ((32'h1 << (IdxHpm3 + NUM_HPM)) - 32'h1) & ~32'h2;

    logic [31:0]     inhibit_q, inhibit_d;
    logic [EvW-1:0]  event_q [HpmA];
    logic [EvW-1:0]  event_d [HpmA];
    logic [PreW-1:0] presc_q, presc_d;
    logic            time_tick;

    logic [63:0]       cnt_val [NumCnt];
    logic [NumCnt-1:0] cnt_inc, cnt_wr_lo, cnt_wr_hi;

    logic        is_user_cnt, is_mach_cnt, is_inh, is_evt, cnt_hi;
    logic [4:0]  cnt_idx;
    logic        addr_ok, illegal, wr_en;
    logic [31:0] rdata, wdata;
    csr_op_e     op;

    assign cnt_hi      = csr_num[7];
    assign cnt_idx     = csr_num[4:0];
    assign is_user_cnt = (csr_num[11:8] == CsrCycle[11:8]) && (csr_num[6:5] == 2'b00);
    assign is_mach_cnt = (csr_num[11:8] == CsrMcycle[11:8]) && (csr_num[6:5] == 2'b00);
    assign is_inh      = (csr_num == CsrMcountinhibit);
    assign is_evt      = (csr_num[11:5] == CsrMhpmevent3[11:5]) && !is_inh;

    always_comb begin
        addr_ok = 1'b0;
        rdata   = '0;
        if (is_user_cnt || is_mach_cnt) begin
            for (int unsigned k = 0; k < NumCnt; k++) begin
                if (cnt_idx == 5'(k) && (is_user_cnt || k != IdxTime)) begin
                    addr_ok = !cnt_hi || (CNT_WIDTH > 32);
                    rdata   = cnt_hi ? cnt_val[k][63:32] : cnt_val[k][31:0];
                end
            end
        end else if (is_inh) begin
            addr_ok = 1'b1;
            rdata   = inhibit_q;
        end else if (is_evt) begin
            for (int unsigned i = 0; i < NUM_HPM; i++) begin
                if (cnt_idx == 5'(IdxHpm3 + i)) begin
                    addr_ok = 1'b1;
                    rdata   = 32'(event_q[i]);
                end
            end
        end
    end

    assign op      = csr_decode_op(write_function);
    assign illegal = (read_csr || write_csr) &&
                     (!addr_ok || (write_csr && (is_user_cnt || op == OpNone)));
    assign wr_en   = write_csr && !illegal;
    assign wdata   = csr_merge(op, rdata, write_value);

    assign read_value              = (read_csr && !illegal) ? rdata : '0;
    assign illegal_instr_exception = illegal;

    assign time_tick = (presc_q == PreW'(TIME_DIV - 1));
    assign presc_d   = time_tick ? '0 : presc_q + PreW'(1);

    always_comb begin
        inhibit_d = inhibit_q;
        event_d   = event_q;
        if (wr_en && is_inh) inhibit_d = wdata & InhMask;
        for (int unsigned i = 0; i < NUM_HPM; i++) begin
            if (wr_en && is_evt && cnt_idx == 5'(IdxHpm3 + i)) event_d[i] = wdata[EvW-1:0];
        end

        for (int unsigned k = 0; k < NumCnt; k++) begin
            cnt_wr_lo[k] = wr_en && is_mach_cnt && !cnt_hi && (cnt_idx == 5'(k));
            cnt_wr_hi[k] = wr_en && is_mach_cnt && cnt_hi && (cnt_idx == 5'(k));
        end

        // Inhibit uses the pre-edge value, so a new inhibit applies from the next cycle.
        cnt_inc[IdxCycle]   = !inhibit_q[IdxCycle];
        cnt_inc[IdxTime]    = time_tick;
        cnt_inc[IdxInstret] = instr_retired && !inhibit_q[IdxInstret];
        for (int unsigned i = 0; i < NUM_HPM; i++) begin
            cnt_inc[IdxHpm3 + i] = 1'b0;
            for (int unsigned e = 0; e < NUM_EVENTS; e++) begin
                if (event_q[i] == EvW'(e + 1) && hpm_events[e]) begin
                    cnt_inc[IdxHpm3 + i] = !inhibit_q[IdxHpm3 + i];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inhibit_q <= '0;
            presc_q   <= '0;
            for (int unsigned i = 0; i < HpmA; i++) event_q[i] <= '0;
        end else begin
            inhibit_q <= inhibit_d;
            presc_q   <= presc_d;
            event_q   <= event_d;
        end
    end

    for (genvar k = 0; k < NumCnt; k++) begin : g_cnt
        logic [CNT_WIDTH-1:0] value;

        csr_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk_i  (clock),
            .rst_i  (reset),
            .inc_i  (cnt_inc[k]),
            .wr_lo_i(cnt_wr_lo[k]),
            .wr_hi_i(cnt_wr_hi[k]),
            .wdata_i(wdata),
            .value_o(value)
        );

        assign cnt_val[k] = 64'(value);
    end

endmodule

// File: doc/csr_counter_bank.md
Name: csr_counter_bank

Overview:
- Parametrised successor to the fixed cycle/time/instret CSR block.
- Implements the RISC-V Zicntr/Zihpm counter set:
  - machine-writable mcycle, minstret and N hardware performance counters;
  - mcountinhibit;
  - programmable mhpmevent selectors;
  - prescaled time;
  - read-only user shadows.
- Sits beside the decode/execute stage:
  - decode presents the CSR number and access type;
  - the bank returns read data combinationally;
  - the bank applies writes at the clock edge.

Parameters:
- CNT_WIDTH, 64: implemented counter width, 32..64. Bits at or above CNT_WIDTH read 0 and ignore writes.
- NUM_HPM, 4: number of hpmcounters implemented, 0..29. These map to indices 3..3+NUM_HPM-1.
- NUM_EVENTS, 8: width of the hpm_events input. The mhpmevent value selects one event; 0 means never count.
- TIME_DIV, 1: clock cycles per time tick, >=1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- instr_retired  in  1  one instruction retired this cycle
- hpm_events  in  NUM_EVENTS  per-cycle event pulses, bit k = event k+1
- csr_num  in  12  CSR address
- read_csr  in  1  read access this cycle
- write_csr  in  1  write access this cycle. Decode deasserts it for CSRRS/CSRRC with a zero operand.
- write_function  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- write_value  in  32  operand, already zero-extended for immediate forms
- read_value  out  32  read data, combinational
- illegal_instr_exception  out  1  access fault, combinational

Behaviour:
- Reset (async): every counter, mcountinhibit and mhpmevent clears to 0, and the time prescaler clears to 0. Outputs are combinational from reset state, so read_value = 0 and illegal_instr_exception = 0.
- Address map:
  - C00/C80 cycle/cycleh
  - C01/C81 time/timeh
  - C02/C82 instret/instreth
  - C03+i/C83+i hpmcounter
  - B00/B80 mcycle/mcycleh
  - B02/B82 minstret/minstreth
  - B03+i/B83+i mhpmcounter
  - 320 mcountinhibit
  - 323+i mhpmevent
- The user Cxx addresses are read-only aliases of the same registers. time has no machine alias.
- Read: read_value is the pre-edge register value. read_value = 0 when read_csr = 0.
- Write new value:
  - RW/RWI: v
  - RS/RSI: old | v
  - RC/RCI: old & ~v
  - other funct3: illegal, no write
- Counter increments (per cycle, unless inhibited):
  - mcycle: +1 every cycle unless mcountinhibit[0].
  - minstret: +1 on instr_retired unless mcountinhibit[2].
  - mhpmcounter(3+i): +1 when mhpmevent(3+i) is in 1..NUM_EVENTS, hpm_events[that-1] = 1, and mcountinhibit[3+i] = 0. Event values out of range never count.
  - time: +1 when the prescaler reaches TIME_DIV-1; the prescaler then wraps to 0. time is not inhibitable.
- Counters wrap modulo 2^CNT_WIDTH silently.
- A write to either half of a counter overrides that counter's increment in the same cycle. The counter holds the written half and the unchanged other half; there is no increment that edge. Example: mcycle = FFFF_FFFF, write mcycleh = 5 → next mcycle = 5_FFFF_FFFF.
- mcountinhibit: bits 1 and 3+NUM_HPM..31 are hardwired 0. An inhibit written this edge takes effect from the next cycle.
- mhpmevent: only the low clog2(NUM_EVENTS+1) bits are stored; the rest read 0.
- Illegal conditions (exception = 1, no state change):
  - read_csr or write_csr to an unimplemented address;
  - write_csr to any Cxx address;
  - high-half (C8x/B8x) access when CNT_WIDTH = 32;
  - write_csr with an invalid funct3.
- Exception = 0 when neither read_csr nor write_csr is asserted.
- Reset asserted mid-count clears immediately; counting resumes on the first edge after deassertion.

Decomposition:
- Package csr_pkg:
  - CSR address constants (base + high offset 0x80);
  - funct3 encodings;
  - mcountinhibit bit indices;
  - the csr_op_e type.
- One natural sub-module, csr_counter: one CNT_WIDTH counter.
  - Inputs: inc enable, write-lo/write-hi strobes, write data.
  - Output: full value.
  - Instantiated for mcycle, time, minstret and each hpm counter.
- The top level holds address decode, RW/RS/RC merge, event muxing, inhibit and the prescaler.

Test Plan:
- Reset, then 10 cycles, read C00 → 10. Read C80 → 0. Assert reset mid-run → cycle reads 0 next sample, with no clock edge needed.
- Write mcountinhibit = 5 (RW), run 20 cycles with instr_retired = 1 → mcycle and minstret frozen. Clear with RC 5 → both resume counting.
- mcycle = FFFF_FFFF via B00 write, 1 cycle → mcycle = 1_0000_0000. Same-cycle write mcycleh = 7 while incrementing → 7_0000_0000 exactly.
- mhpmevent3 = 2, pulse hpm_events[1] 6 times and hpm_events[0] 4 times → hpmcounter3 = 6. mhpmevent3 = NUM_EVENTS+1 → no counting.
- TIME_DIV = 4, 17 cycles after reset → time = 4.
- Write C00, read 0x7FF, write funct3 = 000, read B83+NUM_HPM → illegal_instr_exception = 1 and no register changes. Read 320 with no write → illegal = 0.
